// File: rtl/onehot_pulse_decoder.sv
// Binary code to one-hot strobe decoder with a 2-deep input buffer.
// Each accepted legal code replays as a PULSE_LEN-cycle strobe, then one idle gap.
module onehot_pulse_decoder #(
  parameter int IDX_W     = 2,
  parameter int OUT_W     = 3,
  parameter int PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [IDX_W:0] OUT_LIM = (IDX_W + 1)'(OUT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ctr_q, ctr_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] mem_q [2];
  logic [IDX_W-1:0] mem_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       fill_q, fill_d;

  logic full, empty, accept, legal, push, pop;

  // Ready depends only on registered fill level: no bypass when full.
  assign full   = (fill_q == 2'd2);
  assign empty  = (fill_q == 2'd0);
  assign accept = in_valid && !full;
  assign legal  = ({1'b0, in_idx} < OUT_LIM);
  assign push   = accept && legal;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_idx;
    wr_d   = wr_q ^ push;
    rd_d   = rd_q ^ pop;
    fill_d = fill_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      onehot_q <= '0;
      err_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      onehot_q <= onehot_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      fill_q   <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          ctr_d   = CNT_W'(PULSE_LEN - 1);
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (ctr_q == '0) state_d = GAP;
        else ctr_d = ctr_q - 1'b1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    onehot_d = '0;
    err_d    = accept && !legal;
    unique case (state_q)
      IDLE: begin
        if (!empty) onehot_d = OUT_W'(1) << mem_q[rd_q];
      end
      PULSE: begin
        if (ctr_q != '0) onehot_d = onehot_q;
      end
      default: onehot_d = '0;
    endcase
  end

  assign in_ready   = !full;
  assign out_onehot = onehot_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder with default parameters.
// Strobe shapes are rebuilt from a per-cycle sample log.
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_idx = '0;
  logic       in_ready;
  logic [2:0] out_onehot;
  logic       err;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [2:0] samp[$];
  int sv[$];
  int sl[$];
  int sg[$];

  onehot_pulse_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) samp.push_back(out_onehot);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 100 && (busy || out_onehot != 0); c++) step();
    step();
    chk({"drain_", tag}, {28'd0, busy, out_onehot}, 32'd0);
  endtask

  // Split samples from index 'from' into strobe values, lengths and zero gaps.
  task automatic analyze(input int from);
    int cur, len, zc;
    bit seen;
    cur = 0; len = 0; zc = 0; seen = 0;
    sv.delete(); sl.delete(); sg.delete();
    for (int i = from; i < samp.size(); i++) begin
      int v;
      v = int'(samp[i]);
      if (v != cur) begin
        if (cur != 0) begin
          sv.push_back(cur);
          sl.push_back(len);
        end
        if (v != 0) begin
          if (seen) sg.push_back(zc);
          seen = 1;
          zc = 0;
        end
        cur = v;
        len = 0;
      end
      if (v == 0) zc++;
      else len++;
    end
    if (cur != 0) begin
      sv.push_back(cur);
      sl.push_back(len);
    end
  endtask

  initial begin
    int mark, k;
    bit wa, found;
    int bc[4];
    int ev[4];

    // Reset with valid asserted.
    in_valid = 1'b1;
    in_idx = 2'd1;
    repeat (3) step();
    chk("rst_out", 32'(out_onehot), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_no_accept", 32'(busy), 32'd0);

    // Single code 2.
    in_valid = 1'b1;
    in_idx = 2'd2;
    step();
    in_valid = 1'b0;
    chk("single_n_out", 32'(out_onehot), 32'd0);
    chk("single_n_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("single_n%0d", i), 32'(out_onehot), 32'd4);
    end
    step();
    chk("single_n5", 32'(out_onehot), 32'd0);
    step();
    chk("single_n6", 32'(out_onehot), 32'd0);
    step();
    chk("single_busy_n7", 32'(busy), 32'd0);

    // Burst 0,1,2,1.
    bc = '{0, 1, 2, 1};
    ev = '{1, 2, 4, 2};
    mark = samp.size();
    k = 0;
    for (int c = 0; c < 80 && !(k == 4 && !busy && out_onehot == 0); c++) begin
      in_valid = (k < 4);
      if (k < 4) in_idx = 2'(bc[k]);
      wa = in_valid && in_ready;
      step();
      if (wa) begin
        k++;
        if (k == 3) chk("burst_ready_drop", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("burst_accepts", 32'(k), 32'd4);
    step();
    analyze(mark);
    chk("burst_nstrobes", 32'(sv.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_val%0d", i), 32'(sv[i]), 32'(ev[i]));
      chk($sformatf("burst_len%0d", i), 32'(sl[i]), 32'd4);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("burst_gap%0d", i), 32'(sg[i]), 32'd2);

    // Illegal code during a strobe.
    mark = samp.size();
    in_valid = 1'b1;
    in_idx = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1;
    in_idx = 2'd3;
    chk("illegal_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("illegal_err_hi", 32'(err), 32'd1);
    chk("illegal_out", 32'(out_onehot), 32'd2);
    step();
    chk("illegal_err_lo", 32'(err), 32'd0);
    drain("illegal");
    analyze(mark);
    chk("illegal_nstrobes", 32'(sv.size()), 32'd1);
    chk("illegal_val", 32'(sv[0]), 32'd2);
    chk("illegal_len", 32'(sl[0]), 32'd4);

    // Reset during the second cycle of a 100 strobe with one code queued.
    in_valid = 1'b1;
    in_idx = 2'd2;
    step();
    in_idx = 2'd0;
    step();
    in_valid = 1'b0;
    chk("midrst_c1", 32'(out_onehot), 32'd4);
    step();
    chk("midrst_c2", 32'(out_onehot), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out_onehot), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    mark = samp.size();
    repeat (10) step();
    analyze(mark);
    chk("midrst_quiet", 32'(sv.size()), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    in_valid = 1'b1;
    in_idx = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    chk("midrst_new", 32'(out_onehot), 32'd2);
    drain("midrst");

    // Full boundary: no accept on the pop edge, accept on the next one.
    mark = samp.size();
    in_valid = 1'b1;
    in_idx = 2'd1;
    step();
    in_idx = 2'd2;
    step();
    in_idx = 2'd1;
    step();
    chk("full_ready_low", 32'(in_ready), 32'd0);
    in_idx = 2'd0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (out_onehot == 3'b100) found = 1;
    end
    chk("full_pop_seen", 32'(found), 32'd1);
    chk("full_no_accept_on_pop", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("full_accept_next", 32'(in_ready), 32'd0);
    drain("full");
    analyze(mark);
    ev = '{2, 4, 2, 1};
    chk("full_nstrobes", 32'(sv.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("full_val%0d", i), 32'(sv[i]), 32'(ev[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
